// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - instruction-in / immediate-out stream bundle for imm_extend_pipe
interface imm_extend_pipe_if #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [2:0]         in_fmt;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_imm;
    logic               out_err;

    // Producer of instructions and consumer of immediates (decode stage / bench side)
    modport master (
        output in_valid,
        input  in_ready,
        output in_instr,
        output in_fmt,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_err
    );

    // The extender itself
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_instr,
        input  in_fmt,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - LEGv8 immediate extender with registered output and skid slot; define SHIFT2_EN for byte-offset B/CB results
module imm_extend_pipe #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    imm_extend_pipe_if.slave   bus
);

    localparam logic [2:0] FMT_D  = 3'b000;
    localparam logic [2:0] FMT_I  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_CB = 3'b011;
    localparam logic [2:0] FMT_IW = 3'b100;

    generate
        if (INSTR_W != 32) begin : g_bad_instr_w
            $error("imm_extend_pipe: INSTR_W must be 32");
        end
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("imm_extend_pipe: DATA_W must be 32 or 64");
        end
    endgenerate

    // Decode is done at a fixed 64-bit width and truncated at the end,
    // so the DATA_W=32 build shares the same field logic.
    logic [63:0]        w_ext;
    logic               w_err;
    logic [1:0]         w_hw;
    logic [DATA_W-1:0]  w_imm;
    logic               w_accept;
    logic               w_consume;
    logic               w_unused_bits;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_imm;
    logic               r_out_err;
    logic               r_skid_full;
    logic [DATA_W-1:0]  r_skid_imm;
    logic               r_skid_err;

    assign w_hw          = bus.in_instr[22:21];
    assign w_unused_bits = ^{bus.in_instr[INSTR_W-1:26], w_ext};

    // Field extraction and extension for the selected format
    always_comb begin
        w_ext = 64'd0;
        w_err = 1'b0;
        case (bus.in_fmt)
            FMT_D:  w_ext = {{55{bus.in_instr[20]}}, bus.in_instr[20:12]};
            FMT_I:  w_ext = {52'd0, bus.in_instr[21:10]};
            FMT_B:  w_ext = {{38{bus.in_instr[25]}}, bus.in_instr[25:0]};
            FMT_CB: w_ext = {{45{bus.in_instr[23]}}, bus.in_instr[23:5]};
            FMT_IW: begin
                // A 32-bit datapath cannot hold halfword slots 2 and 3.
                if (DATA_W == 32 && w_hw[1]) begin
                    w_err = 1'b1;
                end else begin
                    w_ext = {48'd0, bus.in_instr[20:5]} << {w_hw, 4'b0000};
                end
            end
            default: w_err = 1'b1;
        endcase
`ifdef SHIFT2_EN
        // Branch offsets become byte offsets here instead of in the target adder.
        if (bus.in_fmt == FMT_B || bus.in_fmt == FMT_CB) begin
            w_ext = {w_ext[61:0], 2'b00};
        end
`else
        // Branch offsets stay in words; the target adder scales them.
`endif
    end

    assign w_imm     = w_ext[DATA_W-1:0];

    // in_ready depends only on the skid slot, never on out_ready.
    assign w_accept  = bus.in_valid & ~r_skid_full;
    assign w_consume = r_out_valid & bus.out_ready;

    // Output register and skid slot: strict FIFO order, skid drains into OUT first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_err   <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_imm  <= '0;
            r_skid_err  <= 1'b0;
        end else if (w_consume && r_skid_full) begin
            // No accept is possible here because in_ready was low.
            r_out_imm   <= r_skid_imm;
            r_out_err   <= r_skid_err;
            r_skid_full <= 1'b0;
        end else if (w_accept && (!r_out_valid || w_consume)) begin
            r_out_valid <= 1'b1;
            r_out_imm   <= w_imm;
            r_out_err   <= w_err;
        end else if (w_accept) begin
            // OUT is held by backpressure; park the new result.
            r_skid_full <= 1'b1;
            r_skid_imm  <= w_imm;
            r_skid_err  <= w_err;
        end else if (w_consume) begin
            // Drained with nothing behind it; imm/err keep their last values.
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = ~r_skid_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_imm   = r_out_imm;
    assign bus.out_err   = r_out_err;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate extractor/extender for the LEGv8 datapath.
- Takes a 32-bit instruction word plus a format select.
- Produces a DATA_W-bit extended immediate through a valid/ready stream.
- Sits between the fetch/decode register and the ALU operand mux / branch-target adder in the pipelined CPU.
- Adds over the single-cycle extender: a MOVZ-style wide-immediate format, an illegal-format flag, a 1-cycle registered output with a 2-entry skid buffer, and optional branch offset scaling.

Parameters:
- DATA_W, 64, output width; legal values 32 or 64.
- INSTR_W, 32, instruction width; fixed at 32, checked at elaboration.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  instruction/format pair present
- in_ready  output  1  block can accept this cycle
- in_instr  input  INSTR_W  instruction word
- in_fmt  input  3  format select
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_imm  output  DATA_W  extended immediate
- out_err  output  1  illegal format or shift out of range; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- State after reset: out_valid=0, out_imm=0, out_err=0, skid empty, in_ready=1. Reset wins over any simultaneous transfer, and data held mid-operation is discarded.
- Formats (bit fields of in_instr):
  - 000 D: imm9 = [20:12], sign-extended.
  - 001 I: imm12 = [21:10], zero-extended.
  - 010 B: imm26 = [25:0], sign-extended.
  - 011 CB: imm19 = [23:5], sign-extended.
  - 100 IW: imm16 = [20:5], zero-extended, then shifted left by 16*hw, where hw = [22:21].
  - 101–111: out_imm=0, out_err=1.
- IW shift range: if DATA_W=32 and hw>=2, out_imm=0 and out_err=1.
- Extension arithmetic: purely combinational from the input fields, then registered. The result is truncated to DATA_W; no other arithmetic.
- Input transfer: occurs when in_valid & in_ready. Output transfer: occurs when out_valid & out_ready.
- Storage: output register OUT and skid register SKID.
- in_ready = !SKID.full. It is registered-state derived and has no combinational path from out_ready.
- Accept while OUT is empty, or while OUT is full and being consumed this cycle with SKID empty: load OUT. Latency is 1 cycle.
- Accept while OUT is full and not consumed: load SKID.
- OUT consumed while SKID is full: OUT<=SKID, SKID empties, and the new input is blocked that cycle (in_ready was 0).
- OUT consumed with SKID empty and no accept: out_valid goes to 0.
- Ordering: strictly FIFO. No data is dropped or duplicated.
- Throughput: 1 result/cycle when out_ready is held high.
- Hold rule: out_imm and out_err hold stable while out_valid=1 and out_ready=0.
- Idle output: when out_valid=0, out_imm and out_err keep their last values. The consumer must ignore them.

Optional Feature:
SHIFT2_EN
- Defined: B and CB results are shifted left by 2 after sign extension, giving byte offsets, with the top bits truncated to DATA_W. The D, I and IW formats are unaffected.
- Undefined: B and CB are word offsets, and the downstream adder performs the shift.

Test Plan:
1. Format decode: each case below sent with out_ready=1, one cycle later out_valid=1, out_err=0.
   - fmt=000, instr=0x001FF000 -> out_imm=0xFFFFFFFFFFFFFFFF.
   - fmt=001, instr=0x003FFC00 -> out_imm=0x0000000000000FFF.
2. Branch formats, with and without SHIFT2_EN:
   - fmt=010, instr=0x02000000 -> 0xFFFFFFFFFE000000; with SHIFT2_EN -> 0xFFFFFFFFF8000000.
   - fmt=011, instr=0x00FFFFE0 -> 0xFFFFFFFFFFFFFFFF; with SHIFT2_EN -> 0xFFFFFFFFFFFFFFFC.
3. Wide immediate and error cases:
   - fmt=100, instr=0x00600020 -> out_imm=0x0001000000000000.
   - fmt=111 -> out_imm=0, out_err=1.
   - DATA_W=32, fmt=100, hw=2 -> out_err=1.
4. Backpressure:
   - Stimulus: out_ready=0, then push A, B, C back-to-back.
   - Required: A held in OUT, B in SKID, in_ready=0 when C is presented; out_imm stays stable.
   - Then raise out_ready: A, B, C emerge in order on consecutive cycles, no loss, in_ready returns to 1.
5. Streaming: 16 random instructions with in_valid and out_ready both held at 1 -> 16 results on 16 consecutive cycles, each matching the reference model.
6. Reset mid-operation: OUT and SKID both full, assert reset for 1 cycle -> next cycle out_valid=0, in_ready=1, out_imm=0, and the old data never appears.
